// File: rtl/i2s_tx_serializer_if.sv
// Sample handshake between a stereo sample source and the I2S transmitter.
interface i2s_tx_serializer_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/i2s_tx_serializer.sv
// Philips-format I2S transmitter: one holding register feeds a 2*DATA_W-bit frame shifter.
// Option I2S_TX_UNDERRUN_HOLD_EN: an underrun replays the last transmitted frame instead of silence.
module i2s_tx_serializer #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_en,
  i2s_tx_serializer_if.slave smp,
  output logic               i2s_bclk,
  output logic               i2s_ws,
  output logic               i2s_sdata,
  output logic               frame_start,
  output logic               underrun
);
  localparam int FRAME_W = 2 * DATA_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] WS_FIRST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] WS_LAST  = BIT_W'(FRAME_W - 2);

  logic [DIV_W-1:0]   div_cnt_r;
  logic [BIT_W-1:0]   bit_cnt_r;
  logic               first_r;
  logic [FRAME_W-1:0] shift_r;
  logic               bclk_r;
  logic               ws_r;
  logic               sdata_r;
  logic               in_ready_r;
  logic [DATA_W-1:0]  hold_left_r;
  logic [DATA_W-1:0]  hold_right_r;
  logic               frame_start_r;
  logic               underrun_r;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
  logic [FRAME_W-1:0] last_frame_r;
`endif

  logic               tick_s;
  logic               fall_s;
  logic               load_s;
  logic               accept_s;
  logic [BIT_W-1:0]   bit_nxt_s;
  logic               ws_nxt_s;
  logic [FRAME_W-1:0] frame_s;
  logic [FRAME_W-1:0] shift_nxt_s;
  logic               sdata_nxt_s;

  // Divider tick, falling-edge/frame-load decode and next shifter contents
  always_comb begin
    tick_s   = tx_en && (div_cnt_r == DIV_LAST);
    fall_s   = tick_s && bclk_r;
    load_s   = fall_s && (first_r || (bit_cnt_r == BIT_LAST));
    accept_s = smp.in_valid && in_ready_r;
    if (first_r || (bit_cnt_r == BIT_LAST)) begin
      bit_nxt_s = {BIT_W{1'b0}};
    end else begin
      bit_nxt_s = bit_cnt_r + BIT_W'(1'b1);
    end
    // ws leads the data by one slot
    ws_nxt_s = (bit_nxt_s >= WS_FIRST) && (bit_nxt_s <= WS_LAST);
    if (!in_ready_r) begin
      frame_s = {hold_left_r, hold_right_r};
    end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
      frame_s = last_frame_r;
`else
      frame_s = {FRAME_W{1'b0}};
`endif
    end
    if (load_s) begin
      sdata_nxt_s = frame_s[FRAME_W-1];
      shift_nxt_s = frame_s << 1'b1;
    end else begin
      sdata_nxt_s = shift_r[FRAME_W-1];
      shift_nxt_s = shift_r << 1'b1;
    end
  end

  // Bit-clock divider, slot counter and serial shifter; disabling discards the partial frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      first_r   <= 1'b1;
      shift_r   <= {FRAME_W{1'b0}};
      bclk_r    <= 1'b0;
      ws_r      <= 1'b0;
      sdata_r   <= 1'b0;
    end else if (!tx_en) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      first_r   <= 1'b1;
      shift_r   <= {FRAME_W{1'b0}};
      bclk_r    <= 1'b0;
      ws_r      <= 1'b0;
      sdata_r   <= 1'b0;
    end else begin
      if (tick_s) begin
        div_cnt_r <= {DIV_W{1'b0}};
        bclk_r    <= ~bclk_r;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
      end
      if (fall_s) begin
        bit_cnt_r <= bit_nxt_s;
        first_r   <= 1'b0;
        ws_r      <= ws_nxt_s;
        sdata_r   <= sdata_nxt_s;
        shift_r   <= shift_nxt_s;
      end
    end
  end

  // Holding register and handshake; a load empties it before any new accept can occur
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r    <= 1'b1;
      hold_left_r   <= {DATA_W{1'b0}};
      hold_right_r  <= {DATA_W{1'b0}};
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      frame_start_r <= load_s;
      underrun_r    <= load_s && in_ready_r;
      if (load_s && !in_ready_r) begin
        in_ready_r <= 1'b1;
      end else if (accept_s) begin
        hold_left_r  <= smp.in_left;
        hold_right_r <= smp.in_right;
        in_ready_r   <= 1'b0;
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_HOLD_EN
  // Remember the last real frame so an underrun can replay it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_frame_r <= {FRAME_W{1'b0}};
    end else if (load_s && !in_ready_r) begin
      last_frame_r <= frame_s;
    end
  end
`endif

  assign smp.in_ready = in_ready_r;
  assign i2s_bclk     = bclk_r;
  assign i2s_ws       = ws_r;
  assign i2s_sdata    = sdata_r;
  assign frame_start  = frame_start_r;
  assign underrun     = underrun_r;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: slot-arithmetic reference model, per-cycle compare and an I2S receiver.
module tb_i2s_tx_serializer;
  localparam int DW    = 16;
  localparam int CD    = 2;
  localparam int FRAME = 2 * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_en = 1'b0;
  logic bclk, ws, sdata, fs, ur;

  i2s_tx_serializer_if #(.DATA_W(DW)) bus ();

  i2s_tx_serializer #(.DATA_W(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .smp(bus),
    .i2s_bclk(bclk), .i2s_ws(ws), .i2s_sdata(sdata),
    .frame_start(fs), .underrun(ur)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs follow from the number of enabled clocks since enable
  int          en_cnt;
  int          m_fr;
  int          slot_q = -1;
  bit          hold_v;
  logic [31:0] hold_q, cur_q, last_q;
  bit          m_acc;
  bit          mdl_init = 1'b0;
  bit          e_bclk, e_ws, e_sd, e_rdy, e_fs, e_ur;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        en_cnt = 0; hold_v = 1'b0; hold_q = 32'h0; cur_q = 32'h0; last_q = 32'h0;
        e_fs = 1'b0; e_ur = 1'b0; mdl_init = 1'b1;
      end else begin
        m_acc = bus.in_valid && !hold_v;
        e_fs = 1'b0; e_ur = 1'b0;
        if (!tx_en) en_cnt = 0;
        else en_cnt++;
        if (en_cnt > 0 && en_cnt % (2 * CD) == 0 && ((en_cnt / (2 * CD)) - 1) % FRAME == 0) begin
          e_fs = 1'b1;
          if (hold_v) begin
            cur_q = hold_q; last_q = hold_q; hold_v = 1'b0;
          end else begin
            e_ur = 1'b1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
            cur_q = last_q;
`else
            cur_q = 32'h0;
`endif
          end
        end
        if (m_acc) begin
          hold_q = {bus.in_left, bus.in_right}; hold_v = 1'b1;
        end
      end
      m_fr   = en_cnt / (2 * CD);
      e_bclk = ((en_cnt / CD) % 2) == 1;
      if (m_fr == 0) begin
        slot_q = -1; e_ws = 1'b0; e_sd = 1'b0;
      end else begin
        slot_q = (m_fr - 1) % FRAME;
        e_ws   = (slot_q >= DW - 1) && (slot_q <= 2 * DW - 2);
        e_sd   = cur_q[FRAME-1-slot_q];
      end
      e_rdy = !hold_v;
    end
  end

  // Compare process plus a ws-delayed I2S receiver capturing on bclk rise
  logic [31:0] rx_q[$];
  logic [15:0] rx_l, rx_r;
  int          rx_rn;
  bit          rx_wsp, prev_bclk;
  int          ur_seen = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mdl_init) begin
        chk("bclk", bclk, e_bclk);
        chk("ws", ws, e_ws);
        chk("sdata", sdata, e_sd);
        chk("in_ready", bus.in_ready, e_rdy);
        chk("frame_start", fs, e_fs);
        chk("underrun", ur, e_ur);
        if (ur === 1'b1) ur_seen++;
      end
      if (rst || !tx_en) begin
        rx_rn = 0; rx_wsp = 1'b0;
      end else if (bclk === 1'b1 && !prev_bclk) begin
        if (!rx_wsp) begin
          rx_l = {rx_l[14:0], sdata};
        end else begin
          rx_r = {rx_r[14:0], sdata};
          rx_rn++;
          if (rx_rn == DW) begin
            rx_q.push_back({rx_l, rx_r});
            rx_rn = 0;
          end
        end
        rx_wsp = ws;
      end
      prev_bclk = rst ? 1'b0 : (bclk === 1'b1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1; bus.in_left = l; bus.in_right = r;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("offer_accepted", done, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int ur0, seq, idx, pos;
  bit acc, hit;
  logic [31:0] pend;

  initial begin
    bus.in_valid = 1'b0; bus.in_left = 16'h0; bus.in_right = 16'h0;
    cyc(3);
    chk("rst_bclk", bclk, 1'b0);
    chk("rst_ws", ws, 1'b0);
    chk("rst_sdata", sdata, 1'b0);
    chk("rst_ready", bus.in_ready, 1'b1);
    chk("rst_fs", fs, 1'b0);
    chk("rst_ur", ur, 1'b0);
    rst = 1'b0;

    // 1: enabled with no input -> silence, underrun every frame
    ur0 = ur_seen; rx_q.delete();
    tx_en = 1'b1;
    cyc(262);
    chk("t1_underruns", ur_seen - ur0, 3);
    chk("t1_frames", rx_q.size(), 2);
    foreach (rx_q[i]) chk("t1_silence", rx_q[i], 32'h0);

    // 2: sample offered before the first frame edge
    tx_en = 1'b0;
    cyc(2);
    offer(16'hA5C3, 16'h8001);
    chk("t2_ready_low", bus.in_ready, 1'b0);
    rx_q.delete();
    tx_en = 1'b1;
    cyc(5);
    chk("t2_ready_back", bus.in_ready, 1'b1);
    cyc(131);
    chk("t2_frames", rx_q.size() >= 1, 1'b1);
    if (rx_q.size() >= 1) chk("t2_frame", rx_q[0], 32'hA5C38001);

    // 3: continuous valid with incrementing samples
    rx_q.delete(); ur0 = ur_seen; seq = 0;
    bus.in_valid = 1'b1; bus.in_left = 16'h1000; bus.in_right = 16'h2000;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk); acc = (bus.in_ready === 1'b1);
      @(posedge clk); #1;
      if (acc) begin
        seq++; bus.in_left = 16'h1000 + 16'(seq); bus.in_right = 16'h2000 + 16'(seq);
      end
    end
    chk("t3_no_underrun", ur_seen - ur0, 0);
    idx = 0;
    foreach (rx_q[i]) begin
      if (rx_q[i][31:28] == 4'h1) begin
        chk("t3_seq_frame", rx_q[i], 32'h10002000 + 32'(idx) * 32'h00010001);
        idx++;
      end
    end
    chk("t3_frame_count", idx >= 3, 1'b1);

    // 4: disable at slot 20 with the holding register full, re-enable after 10 clk
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk); acc = (bus.in_ready === 1'b1);
      @(posedge clk); #1;
      if (acc) begin
        seq++; bus.in_left = 16'h1000 + 16'(seq); bus.in_right = 16'h2000 + 16'(seq);
      end
      if (slot_q == 20 && hold_v) hit = 1'b1;
    end
    chk("t4_reached_slot20", hit, 1'b1);
    tx_en = 1'b0; bus.in_valid = 1'b0;
    pend = {16'h1000 + 16'(seq - 1), 16'h2000 + 16'(seq - 1)};
    cyc(3);
    chk("t4_off_bclk", bclk, 1'b0);
    chk("t4_off_ws", ws, 1'b0);
    chk("t4_off_sdata", sdata, 1'b0);
    chk("t4_off_ready", bus.in_ready, 1'b0);
    cyc(7);
    rx_q.delete();
    tx_en = 1'b1;
    cyc(140);
    chk("t4_frames", rx_q.size() >= 1, 1'b1);
    if (rx_q.size() >= 1) chk("t4_restart_frame", rx_q[0], pend);

    // 5: asynchronous reset mid-frame with the holding register full
    offer(16'hDEAD, 16'hBEEF);
    cyc(7);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_bclk", bclk, 1'b0);
    chk("t5_ws", ws, 1'b0);
    chk("t5_sdata", sdata, 1'b0);
    chk("t5_ready", bus.in_ready, 1'b1);
    chk("t5_fs", fs, 1'b0);
    chk("t5_ur", ur, 1'b0);
    cyc(2);
    rst = 1'b0;
    ur0 = ur_seen;
    cyc(8);
    chk("t5_next_underrun", ur_seen - ur0, 1);

    // 6: underrun following frame 1234/5678
    rx_q.delete();
    offer(16'h1234, 16'h5678);
    cyc(3 * 128 + 20);
    pos = -1;
    foreach (rx_q[i]) if (pos < 0 && rx_q[i] == 32'h12345678) pos = i;
    chk("t6_frame_seen", pos >= 0, 1'b1);
    chk("t6_next_present", (pos >= 0) && (pos + 1 < rx_q.size()), 1'b1);
    if (pos >= 0 && pos + 1 < rx_q.size()) begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
      chk("t6_after_underrun", rx_q[pos+1], 32'h12345678);
`else
      chk("t6_after_underrun", rx_q[pos+1], 32'h00000000);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
